// File: rtl/mac_job_ctrl_pkg.sv
// rtl/mac_job_ctrl_pkg.sv - shared types and widths for the MAC job sequencer
package mac_job_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int RES_W  = 17;

  typedef enum logic {
    OP_DOT    = 1'b0,
    OP_HORNER = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/mac_job_ctrl_len_cnt.sv
// rtl/mac_job_ctrl_len_cnt.sv - loadable terms-remaining down-counter with last flag
module mac_job_ctrl_len_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);
  logic [LEN_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  assign o_last = (r_cnt == LEN_W'(1));
endmodule

// File: rtl/mac_job_ctrl.sv
// rtl/mac_job_ctrl.sv - job sequencer for the 8x8 MAC with 2-deep feedback loop
// Optional: MAC_JOB_CTRL_WRAP_DET_EN adds res_wrap (DOT accumulator wrap flag).
module mac_job_ctrl
  import mac_job_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              start_ready,
  input  logic              start_op,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [DATA_W-1:0] start_x,
  input  logic              opnd_valid,
  output logic              opnd_ready,
  input  logic [DATA_W-1:0] opnd_a,
  input  logic [DATA_W-1:0] opnd_b,
  output logic [DATA_W-1:0] mac_in_1,
  output logic [DATA_W-1:0] mac_in_2,
  output logic [DATA_W-1:0] mac_in_add,
  output logic              mac_mul_sel,
  output logic              mac_add_sel,
  output logic              mac_mode,
  input  logic [RES_W-1:0]  mac_output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data
`ifdef MAC_JOB_CTRL_WRAP_DET_EN
  ,
  output logic              res_wrap
`endif
);
  state_e                r_state;
  state_e                w_state_nxt;
  op_e                   r_op;
  logic [DATA_W-1:0]     r_x;
  logic                  r_slot;
  logic                  r_first;
  logic                  r_drain;
  logic [RES_W-1:0]      r_res_data;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_last;
  logic                  w_sample;

  assign w_accept = start && (r_state == IDLE);
  assign w_issue  = (r_state == ISSUE) && !r_slot && opnd_valid;
  // DOT reads adder_out one cycle after the last issue; HORNER waits for it to reach intermediate.
  assign w_sample = (r_state == DRAIN) && ((r_op == OP_DOT) || r_drain);

  mac_job_ctrl_len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (start_len),
    .i_dec      (w_issue),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= OP_DOT;
      r_x        <= '0;
      r_slot     <= 1'b0;
      r_first    <= 1'b0;
      r_drain    <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= (r_state == ISSUE) ? ~r_slot : 1'b0;
      r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
      if (w_accept) begin
        r_op    <= op_e'(start_op);
        r_x     <= start_x;
        r_first <= 1'b1;
      end else if (w_issue) begin
        r_first <= 1'b0;
      end
      if (w_accept && (start_len == '0)) begin
        r_res_data <= '0;
      end else if (w_sample) begin
        r_res_data <= mac_output;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mac_in_1    = '0;
    mac_in_2    = '0;
    mac_in_add  = '0;
    mac_mul_sel = 1'b0;
    mac_add_sel = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (start_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Idle slots recirculate intermediate so the accumulator keeps its phase.
        mac_add_sel = 1'b1;
        if (w_issue) begin
          if (r_op == OP_DOT) begin
            mac_in_1    = opnd_a;
            mac_in_2    = opnd_b;
            mac_add_sel = !r_first;
          end else begin
            mac_mul_sel = !r_first;
            mac_in_2    = r_first ? '0 : r_x;
            mac_in_add  = opnd_a;
            mac_add_sel = 1'b0;
          end
          if (w_last) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        mac_add_sel = 1'b1;
        if (w_sample) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign start_ready = (r_state == IDLE);
  assign opnd_ready  = (r_state == ISSUE) && !r_slot;
  assign mac_mode    = r_op;
  assign res_valid   = (r_state == DONE);
  assign res_data    = r_res_data;

`ifdef MAC_JOB_CTRL_WRAP_DET_EN
  logic             r_chk;
  logic [RES_W-1:0] r_prev_acc;
  logic             r_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chk      <= 1'b0;
      r_prev_acc <= '0;
      r_wrap     <= 1'b0;
    end else if (w_accept) begin
      r_chk      <= 1'b0;
      r_prev_acc <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_chk <= w_issue && (r_op == OP_DOT);
      if (r_chk) begin
        if (mac_output < r_prev_acc) begin
          r_wrap <= 1'b1;
        end
        r_prev_acc <= mac_output;
      end
    end
  end

  assign res_wrap = r_wrap;
`endif
endmodule

// File: tb/tb_mac_job_ctrl.sv
// tb/tb_mac_job_ctrl.sv - self-checking bench for mac_job_ctrl with a behavioural MAC
module tb_mac_job_ctrl;
  import mac_job_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, start_ready, start_op;
  logic [7:0]  start_len, start_x;
  logic        opnd_valid, opnd_ready;
  logic [7:0]  opnd_a, opnd_b;
  logic [7:0]  mac_in_1, mac_in_2, mac_in_add;
  logic        mac_mul_sel, mac_add_sel, mac_mode;
  logic [16:0] mac_output;
  logic        res_valid, res_ready;
  logic [16:0] res_data;
`ifdef MAC_JOB_CTRL_WRAP_DET_EN
  logic        res_wrap;
`endif

  always #5 clk = ~clk;

  mac_job_ctrl #(.LEN_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_ready (start_ready),
    .start_op    (start_op),
    .start_len   (start_len),
    .start_x     (start_x),
    .opnd_valid  (opnd_valid),
    .opnd_ready  (opnd_ready),
    .opnd_a      (opnd_a),
    .opnd_b      (opnd_b),
    .mac_in_1    (mac_in_1),
    .mac_in_2    (mac_in_2),
    .mac_in_add  (mac_in_add),
    .mac_mul_sel (mac_mul_sel),
    .mac_add_sel (mac_add_sel),
    .mac_mode    (mac_mode),
    .mac_output  (mac_output),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
`ifdef MAC_JOB_CTRL_WRAP_DET_EN
    ,
    .res_wrap    (res_wrap)
`endif
  );

  // Behavioural MAC datapath: adder_out feeds intermediate, intermediate feeds back.
  logic [16:0] m_add, m_int, m_add_b;
  logic [7:0]  m_mul_a;
  logic [15:0] m_prod;
  always_comb begin
    m_mul_a = mac_mul_sel ? m_int[7:0] : mac_in_1;
    m_prod  = {8'd0, m_mul_a} * {8'd0, mac_in_2};
    m_add_b = mac_add_sel ? m_int : {9'd0, mac_in_add};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_add <= '0;
      m_int <= '0;
    end else begin
      m_add <= {1'b0, m_prod} + m_add_b;
      m_int <= m_add;
    end
  end
  assign mac_output = mac_mode ? m_int : m_add;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] ja [16];
  logic [7:0] jb [16];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] model_res(input logic op, input int len, input logic [7:0] x);
    int acc = 0;
    for (int k = 0; k < len; k++) begin
      if (op == 1'b0) acc = (acc + int'(ja[k]) * int'(jb[k])) % 131072;
      else            acc = ((acc % 256) * int'(x) + int'(ja[k])) % 131072;
    end
    return 17'(acc);
  endfunction

  function automatic logic model_wrap(input logic op, input int len);
    int prev = 0;
    int cur;
    logic w = 1'b0;
    if (op == 1'b0) begin
      for (int k = 0; k < len; k++) begin
        cur = (prev + int'(ja[k]) * int'(jb[k])) % 131072;
        if (cur < prev) w = 1'b1;
        prev = cur;
      end
    end
    return w;
  endfunction

  // Runs one job starting #1 after a posedge; returns result, latency and protocol flags.
  task automatic run_job(input logic op, input int len, input logic [7:0] x, input int gap,
                         input int hold, output logic [16:0] res, output int lat,
                         output logic wrp, output bit proto_ok, output bit done_ok);
    int k = 0;
    int c = 0;
    int gl = 0;
    proto_ok = 1'b1;
    done_ok  = 1'b1;
    res = '0;
    lat = -1;
    wrp = 1'b0;
    start = 1'b1; start_op = op; start_len = 8'(len); start_x = x;
    opnd_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    if (start_ready !== 1'b1) proto_ok = 1'b0;
    @(posedge clk); #1;
    while (k < len && c < 500) begin
      start = 1'($urandom); start_op = 1'($urandom);
      start_len = 8'($urandom); start_x = 8'($urandom);
      if (gl > 0) begin
        opnd_valid = 1'b0; opnd_a = 8'($urandom); opnd_b = 8'($urandom); gl--;
      end else begin
        opnd_valid = 1'b1; opnd_a = ja[k]; opnd_b = jb[k];
      end
      @(negedge clk);
      if (opnd_ready !== ((c % 2) == 0)) proto_ok = 1'b0;
      if (start_ready !== 1'b0 || res_valid !== 1'b0) proto_ok = 1'b0;
      if (opnd_valid && opnd_ready) begin
        k++;
        gl = gap;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    opnd_valid = 1'b0;
    if (k < len) begin
      proto_ok = 1'b0;
      done_ok = 1'b0;
      return;
    end
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (res_valid === 1'b1) break;
      if (opnd_ready !== 1'b0 || start_ready !== 1'b0) proto_ok = 1'b0;
    end
    res = res_data;
`ifdef MAC_JOB_CTRL_WRAP_DET_EN
    wrp = res_wrap;
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== res) done_ok = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    if (start_ready !== 1'b1 || res_valid !== 1'b0) done_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        op;
    logic [7:0]  len;
    logic [7:0]  x;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  gap;
    logic [3:0]  hold;
    logic [16:0] exp_res;
    logic [3:0]  exp_lat;
    logic        exp_wrap;
  } vec_t;

  function automatic logic [31:0] mk4(input logic [7:0] e0, input logic [7:0] e1,
                                      input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  vec_t        vecs [6];
  logic [16:0] r;
  int          lat;
  logic        w;
  bit          p, d;
  logic        rop;
  int          rlen;
  logic [7:0]  rx;

  initial begin
    start = 0; start_op = 0; start_len = 0; start_x = 0;
    opnd_valid = 0; opnd_a = 0; opnd_b = 0; res_ready = 0;
    #1 reset = 1'b1;
    #2;
    chk("reset_start_ready", start_ready, 1);
    chk("reset_opnd_ready", opnd_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_mac_ctrl", {mac_in_1, mac_in_2, mac_in_add, mac_mul_sel, mac_add_sel, mac_mode}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    vecs[0] = '{op:1'b0, len:8'd3, x:8'd0, a:mk4(1,2,3,0), b:mk4(4,5,6,0), gap:4'd0, hold:4'd0,
                exp_res:17'd32, exp_lat:4'd2, exp_wrap:1'b0};
    vecs[1] = '{op:1'b1, len:8'd3, x:8'd2, a:mk4(1,0,3,0), b:mk4(9,9,9,9), gap:4'd0, hold:4'd1,
                exp_res:17'd7, exp_lat:4'd3, exp_wrap:1'b0};
    vecs[2] = '{op:1'b0, len:8'd3, x:8'd0, a:mk4(1,2,3,0), b:mk4(4,5,6,0), gap:4'd3, hold:4'd0,
                exp_res:17'd32, exp_lat:4'd2, exp_wrap:1'b0};
    vecs[3] = '{op:1'b0, len:8'd0, x:8'd0, a:mk4(7,7,7,7), b:mk4(7,7,7,7), gap:4'd0, hold:4'd5,
                exp_res:17'd0, exp_lat:4'd1, exp_wrap:1'b0};
    vecs[4] = '{op:1'b0, len:8'd3, x:8'd0, a:mk4(255,255,255,0), b:mk4(255,255,255,0), gap:4'd0,
                hold:4'd0, exp_res:17'd64003, exp_lat:4'd2, exp_wrap:1'b1};
    vecs[5] = '{op:1'b0, len:8'd2, x:8'd0, a:mk4(255,255,0,0), b:mk4(255,255,0,0), gap:4'd1,
                hold:4'd2, exp_res:17'd130050, exp_lat:4'd2, exp_wrap:1'b0};

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        ja[k] = vecs[i].a[k*8 +: 8];
        jb[k] = vecs[i].b[k*8 +: 8];
      end
      run_job(vecs[i].op, int'(vecs[i].len), vecs[i].x, int'(vecs[i].gap), int'(vecs[i].hold),
              r, lat, w, p, d);
      chk($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_protocol", i), p, 1);
      chk($sformatf("vec%0d_hold_release", i), d, 1);
`ifdef MAC_JOB_CTRL_WRAP_DET_EN
      chk($sformatf("vec%0d_wrap", i), w, vecs[i].exp_wrap);
`endif
    end

    for (int j = 0; j < 25; j++) begin
      rop  = 1'($urandom);
      rlen = $urandom_range(0, 12);
      rx   = 8'($urandom);
      for (int k = 0; k < 16; k++) begin
        ja[k] = (j % 5 == 4) ? 8'd255 : 8'($urandom);
        jb[k] = (j % 5 == 4) ? 8'd255 : 8'($urandom);
      end
      run_job(rop, rlen, rx, $urandom_range(0, 3), $urandom_range(0, 2), r, lat, w, p, d);
      chk($sformatf("rnd%0d_res", j), r, model_res(rop, rlen, rx));
      chk($sformatf("rnd%0d_latency", j), lat, (rlen == 0) ? 1 : (rop ? 3 : 2));
      chk($sformatf("rnd%0d_protocol", j), p & d, 1);
`ifdef MAC_JOB_CTRL_WRAP_DET_EN
      chk($sformatf("rnd%0d_wrap", j), w, model_wrap(rop, rlen));
`endif
    end

    start = 1'b1; start_op = 1'b0; start_len = 8'd5; start_x = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; opnd_valid = 1'b1; opnd_a = 8'd9; opnd_b = 8'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("midjob_busy", start_ready, 0);
    reset = 1'b1;
    #1;
    chk("midjob_reset_start_ready", start_ready, 1);
    chk("midjob_reset_res_valid", res_valid, 0);
    chk("midjob_reset_opnd_ready", opnd_ready, 0);
    opnd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    ja[0] = 8'd1;
    jb[0] = 8'd1;
    run_job(1'b0, 1, 8'd0, 0, 0, r, lat, w, p, d);
    chk("after_reset_res", r, 1);
    chk("after_reset_latency", lat, 2);
    chk("after_reset_protocol", p & d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
